alu_op_dispatcher: RTL and testbench
====================================

ALU_OP_DISPATCHER -- requirements
Module: alu_op_dispatcher

Interface
REQ-001 SHALL have parameter DEPTH, default 4, operand FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TAG_W, default 4, width of the caller's operation tag.
REQ-003 SHALL have ports:
- Clock  in  1  single clock, all state on rising edge
- Reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted this edge when high with in_valid
- in_funsel  in  5  ALU FunSel code
- in_a, in_b  in  32  operands
- in_wf  in  1  request flag write
- in_tag  in  TAG_W  caller tag
- alu_a, alu_b  out  32  operands to ALU
- alu_funsel  out  5  FunSel to ALU
- alu_wf  out  1  WF to ALU
- alu_out  in  32  ALU result, registered in ALU
- alu_flags  in  4  ALU flags {Z,C,N,O}
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_data  out  32  captured result
- res_flags  out  4  captured flags
- res_tag  out  TAG_W  tag of the result
REQ-004 Clock is the single clock; Reset is asynchronous and active-low.

Function
REQ-005 SHALL buffer accepted operations {funsel,a,b,wf,tag} in a DEPTH-entry FIFO; in_ready = not full (registered count, no same-edge push-when-full even if a pop occurs).
REQ-006 SHALL run FSM IDLE, EXEC, CAPT, RESP; one operation in flight at a time.
REQ-007 IDLE: FIFO non-empty -> pop head into operand registers, go EXEC; else stay.
REQ-008 EXEC (one cycle): alu_a/alu_b/alu_funsel from operand registers, alu_wf = op's wf; go CAPT.
REQ-009 CAPT (one cycle): alu_wf=0; at edge latch alu_out->res_data, alu_flags->res_flags, tag->res_tag; go RESP.
REQ-010 RESP: res_valid=1; res_data/flags/tag stable until handshake; on res_ready: FIFO non-empty -> pop, go EXEC; else IDLE.
REQ-011 alu_wf SHALL be 0 in every state except EXEC, so ALU flags change only for the dispatched op.
REQ-012 Outside EXEC alu_a/alu_b/alu_funsel SHALL hold last operand-register values.
REQ-013 Latency: accept edge to res_valid rising = 3 edges when FIFO empty and FSM IDLE; throughput one op per 3 cycles with res_ready held high.
REQ-014 FIFO pointers SHALL wrap modulo DEPTH; order preserved across wrap.
REQ-015 res_ready low in RESP SHALL stall issue; FIFO keeps accepting until full.
REQ-016 res_valid SHALL be 0 in IDLE, EXEC, CAPT.

Reset
REQ-017 Reset low SHALL immediately force: FSM IDLE, FIFO empty, in_ready=1 after release, res_valid=0, alu_wf=0, alu_a/alu_b/res_data=0, alu_funsel=0, res_flags=0, res_tag=0.
REQ-018 Reset mid-operation SHALL discard buffered and in-flight ops; no result produced for them.

Configuration
REQ-019 With ALU_DISPATCH_BYPASS_EN defined: in IDLE with FIFO empty, an accepted op SHALL load operand registers directly (FIFO untouched), entering EXEC next cycle; latency 2 edges.
REQ-020 Without ALU_DISPATCH_BYPASS_EN: all ops pass through the FIFO; latency per REQ-013.

Structure
REQ-021 Shared package alu_dispatch_pkg SHALL hold FunSel code constants, flag bit indices (Z=3,C=2,N=1,O=0), and the FSM state enum.
REQ-022 FIFO SHALL be sub-module alu_dispatch_fifo (DEPTH, width params, push/pop/full/empty).

Verification
REQ-023 Bench with behavioural ALU model SHALL cover:
- Single op funsel 5'b10100, a=0x5, b=0x3, wf=1, tag=0x1 -> res_data=0x8, res_flags Z=0, tag 0x1, res_valid 3 edges after accept (2 with bypass).
- Op wf=0 after op producing Z=1 -> res_flags still show Z=1; alu_wf never high.
- Push 5 ops with res_ready=0, DEPTH=4 -> first issued, in_ready low after 4 buffered; release res_ready -> all 5 results in tag order.
- 12 back-to-back ops, res_ready=1 -> tags 0..11 in order, pointer wrap exercised, one result per 3 cycles.
- Reset asserted during CAPT with 2 ops buffered -> res_valid stays 0, FIFO empty, no stale result after release.
- Continuous res_ready toggling during RESP -> res_data/tag held stable while res_valid&!res_ready.

Source files
------------

// File: rtl/alu_dispatch_pkg.sv
// Shared definitions for the ALU operation dispatcher: FunSel codes, flag bit
// positions and the dispatcher FSM state encoding.
package alu_dispatch_pkg;

  localparam logic [4:0] FS_PASS_A = 5'b10000;
  localparam logic [4:0] FS_PASS_B = 5'b10001;
  localparam logic [4:0] FS_NOT_A  = 5'b10010;
  localparam logic [4:0] FS_ADD    = 5'b10100;
  localparam logic [4:0] FS_SUB    = 5'b10110;
  localparam logic [4:0] FS_AND    = 5'b10111;
  localparam logic [4:0] FS_OR     = 5'b11000;
  localparam logic [4:0] FS_XOR    = 5'b11001;

  // Flag vector layout {Z,C,N,O}
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/alu_dispatch_fifo.sv
// Operand FIFO: DEPTH entries (power of two), head visible combinationally.
// full/empty come from a registered count, so a pop never frees a slot on the same edge.
module alu_dispatch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_op_dispatcher.sv
// Buffers ALU operations and issues them one at a time (IDLE/EXEC/CAPT/RESP), capturing result, flags and tag.
// Optional ALU_DISPATCH_BYPASS_EN lets an op arriving at an idle, empty dispatcher skip the FIFO.
module alu_op_dispatcher
  import alu_dispatch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_funsel,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_wf,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [4:0]       alu_funsel,
  output logic             alu_wf,
  input  logic [31:0]      alu_out,
  input  logic [3:0]       alu_flags,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [3:0]       res_flags,
  output logic [TAG_W-1:0] res_tag
);

  localparam int OP_W = 5 + 32 + 32 + 1 + TAG_W;

  state_t           state;
  logic [TAG_W-1:0] op_tag;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic             bypass_take;
  logic [OP_W-1:0]  fifo_wdata;
  logic [OP_W-1:0]  fifo_rdata;
  logic [4:0]       head_funsel;
  logic [31:0]      head_a;
  logic [31:0]      head_b;
  logic             head_wf;
  logic [TAG_W-1:0] head_tag;

  assign fifo_wdata = {in_funsel, in_a, in_b, in_wf, in_tag};
  assign {head_funsel, head_a, head_b, head_wf, head_tag} = fifo_rdata;

  assign in_ready = !fifo_full;

`ifdef ALU_DISPATCH_BYPASS_EN
  assign bypass_take = (state == ST_IDLE) && fifo_empty && in_valid;
`else
  assign bypass_take = 1'b0;
`endif

  assign fifo_push = in_valid && in_ready && !bypass_take;
  assign fifo_pop  = !fifo_empty &&
                     ((state == ST_IDLE) || ((state == ST_RESP) && res_ready));

  alu_dispatch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OP_W)
  ) u_fifo (
    .Clock     (Clock),
    .Reset     (Reset),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // alu_a/alu_b/alu_funsel double as the operand registers, so they hold between ops
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= ST_IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_funsel <= '0;
      alu_wf     <= 1'b0;
      op_tag     <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_flags  <= '0;
      res_tag    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            alu_funsel <= head_funsel;
            alu_a      <= head_a;
            alu_b      <= head_b;
            alu_wf     <= head_wf;
            op_tag     <= head_tag;
            state      <= ST_EXEC;
          end else if (bypass_take) begin
            alu_funsel <= in_funsel;
            alu_a      <= in_a;
            alu_b      <= in_b;
            alu_wf     <= in_wf;
            op_tag     <= in_tag;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          alu_wf <= 1'b0;
          state  <= ST_CAPT;
        end
        ST_CAPT: begin
          res_data  <= alu_out;
          res_flags <= alu_flags;
          res_tag   <= op_tag;
          res_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (fifo_pop) begin
              alu_funsel <= head_funsel;
              alu_a      <= head_a;
              alu_b      <= head_b;
              alu_wf     <= head_wf;
              op_tag     <= head_tag;
              state      <= ST_EXEC;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Randomised scoreboard bench for alu_op_dispatcher with a behavioural registered ALU.
module tb_alu_op_dispatcher;
  import alu_dispatch_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
`ifdef ALU_DISPATCH_BYPASS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  logic             Clock = 1'b0;
  logic             Reset;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_funsel;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             in_wf;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [4:0]       alu_funsel;
  logic             alu_wf;
  logic [31:0]      alu_out;
  logic [3:0]       alu_flags;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [3:0]       res_flags;
  logic [TAG_W-1:0] res_tag;

  always #5 Clock = ~Clock;

  alu_op_dispatcher #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_funsel  (in_funsel),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_wf      (in_wf),
    .in_tag     (in_tag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_funsel (alu_funsel),
    .alu_wf     (alu_wf),
    .alu_out    (alu_out),
    .alu_flags  (alu_flags),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_flags  (res_flags),
    .res_tag    (res_tag)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flags;
  } alu_res_t;

  typedef struct {
    logic [31:0]      data;
    logic [3:0]       flags;
    logic [TAG_W-1:0] tag;
  } exp_t;

  function automatic alu_res_t alu_fn(logic [4:0] fs, logic [31:0] a, logic [31:0] b);
    alu_res_t r;
    logic [32:0] w;
    logic c;
    logic o;
    r = '0;
    w = '0;
    c = 1'b0;
    o = 1'b0;
    case (fs)
      FS_PASS_A: r.res = a;
      FS_PASS_B: r.res = b;
      FS_NOT_A:  r.res = ~a;
      FS_ADD: begin
        w = {1'b0, a} + {1'b0, b};
        r.res = w[31:0];
        c = w[32];
        o = (a[31] == b[31]) && (w[31] != a[31]);
      end
      FS_SUB: begin
        w = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r.res = w[31:0];
        c = w[32];
        o = (a[31] != b[31]) && (w[31] != a[31]);
      end
      FS_AND: r.res = a & b;
      FS_OR:  r.res = a | b;
      FS_XOR: r.res = a ^ b;
      default: r.res = '0;
    endcase
    r.flags[FLAG_Z] = (r.res == 32'd0);
    r.flags[FLAG_C] = c;
    r.flags[FLAG_N] = r.res[31];
    r.flags[FLAG_O] = o;
    return r;
  endfunction

  function automatic logic [4:0] rand_fs();
    case ($urandom_range(0, 7))
      0: return FS_PASS_A;
      1: return FS_PASS_B;
      2: return FS_NOT_A;
      3: return FS_ADD;
      4: return FS_SUB;
      5: return FS_AND;
      6: return FS_OR;
      default: return FS_XOR;
    endcase
  endfunction

  // Registered ALU: result every cycle, flags only when write-flag is set
  alu_res_t alu_comb;
  assign alu_comb = alu_fn(alu_funsel, alu_a, alu_b);

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      alu_out   <= '0;
      alu_flags <= '0;
    end else begin
      alu_out <= alu_comb.res;
      if (alu_wf) alu_flags <= alu_comb.flags;
    end
  end

  exp_t        exp_q[$];
  int          hs_cycle[$];
  logic [3:0]  model_flags;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_results = 0;
  int          wf_seen = 0;
  int          cyc = 0;
  bit          drv_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // Offer one op; expected response is queued at the accepting edge
  task automatic send_op(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                         input logic wf, input logic [TAG_W-1:0] tag);
    bit rdy;
    bit accepted;
    alu_res_t r;
    exp_t e;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_funsel = fs;
    in_a = a;
    in_b = b;
    in_wf = wf;
    in_tag = tag;
    for (int k = 0; k < 300 && !accepted; k++) begin
      rdy = in_ready;
      @(posedge Clock);
      #1;
      if (rdy) begin
        accepted = 1'b1;
        r = alu_fn(fs, a, b);
        if (wf) model_flags = r.flags;
        e.data = r.res;
        e.flags = model_flags;
        e.tag = tag;
        exp_q.push_back(e);
      end
    end
    in_valid = 1'b0;
    if (!accepted) timeout_fail("send_accept");
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!res_valid && n < 60) begin
      step(1);
      n++;
    end
    if (!res_valid) timeout_fail("wait_res_valid");
  endtask

  task automatic take_one();
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      step(1);
      k++;
    end
    if (exp_q.size() != 0) timeout_fail("drain");
  endtask

  task automatic burst(input int n, input bit toggle);
    int k;
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < n; i++)
          send_op(rand_fs(), $urandom, $urandom, 1'($urandom), TAG_W'(i));
        drv_done = 1'b1;
      end
    join_none
    k = 0;
    while (!(drv_done && exp_q.size() == 0) && k < 3000) begin
      if (toggle) res_ready = 1'($urandom);
      step(1);
      k++;
    end
    wait fork;
    if (!(drv_done && exp_q.size() == 0)) timeout_fail("burst_drain");
    res_ready = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every result handshake, checks hold while stalled
  initial begin : monitor
    bit          hold_prev;
    logic [31:0] prev_data;
    logic [3:0]  prev_flags;
    logic [TAG_W-1:0] prev_tag;
    exp_t        e;
    hold_prev = 1'b0;
    prev_data = '0;
    prev_flags = '0;
    prev_tag = '0;
    forever begin
      @(negedge Clock);
      cyc++;
      if (Reset !== 1'b1) begin
        hold_prev = 1'b0;
      end else begin
        if (alu_wf) wf_seen++;
        if (hold_prev) begin
          check("hold_res_valid", 32'(res_valid), 32'd1);
          check("hold_res_data", res_data, prev_data);
          check("hold_res_flags", 32'(res_flags), 32'(prev_flags));
          check("hold_res_tag", 32'(res_tag), 32'(prev_tag));
        end
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got tag 0x%0h, required no result", res_tag);
          end else begin
            e = exp_q.pop_front();
            check("res_data", res_data, e.data);
            check("res_flags", 32'(res_flags), 32'(e.flags));
            check("res_tag", 32'(res_tag), 32'(e.tag));
          end
          n_results++;
          hs_cycle.push_back(cyc);
        end
        hold_prev = res_valid && !res_ready;
        prev_data = res_data;
        prev_flags = res_flags;
        prev_tag = res_tag;
      end
    end
  end

  initial begin
    int n;
    int base;
    int wf_before;
    int res_before;
    Reset = 1'b0;
    in_valid = 1'b0;
    in_funsel = '0;
    in_a = '0;
    in_b = '0;
    in_wf = 1'b0;
    in_tag = '0;
    res_ready = 1'b0;
    model_flags = '0;
    step(2);

    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_alu_wf", 32'(alu_wf), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_funsel", 32'(alu_funsel), 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_flags", 32'(res_flags), 32'd0);
    check("rst_res_tag", 32'(res_tag), 32'd0);
    Reset = 1'b1;
    step(1);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Single ADD: latency and captured values
    send_op(FS_ADD, 32'h5, 32'h3, 1'b1, 4'h1);
    wait_valid(n);
    check("t1_latency", 32'(n), 32'(LAT));
    check("t1_res_data", res_data, 32'h8);
    check("t1_flag_z", 32'(res_flags[FLAG_Z]), 32'd0);
    check("t1_res_tag", 32'(res_tag), 32'h1);
    take_one();

    // Z from a flag-writing op survives a following op without write-flag
    send_op(FS_SUB, 32'h7, 32'h7, 1'b1, 4'h2);
    wait_valid(n);
    check("t2_sub_flag_z", 32'(res_flags[FLAG_Z]), 32'd1);
    take_one();
    wf_before = wf_seen;
    send_op(FS_ADD, 32'h1, 32'h2, 1'b0, 4'h3);
    wait_valid(n);
    check("t2_res_data", res_data, 32'h3);
    check("t2_flag_z_kept", 32'(res_flags[FLAG_Z]), 32'd1);
    check("t2_alu_wf_quiet", 32'(wf_seen), 32'(wf_before));
    take_one();
    step(2);

    // Fill the FIFO behind a stalled result
    for (int i = 0; i < 5; i++)
      send_op(rand_fs(), $urandom, $urandom, 1'($urandom), TAG_W'(4 + i));
    check("t3_in_ready_full", 32'(in_ready), 32'd0);
    wait_valid(n);
    check("t3_first_tag", 32'(res_tag), 32'd4);
    step(3);
    check("t3_in_ready_still_full", 32'(in_ready), 32'd0);
    res_ready = 1'b1;
    drain();
    step(3);

    // Back-to-back stream: order across pointer wrap and 3-cycle cadence
    base = hs_cycle.size();
    burst(12, 1'b0);
    if (hs_cycle.size() < base + 12) begin
      timeout_fail("t4_result_count");
    end else begin
      for (int i = 1; i < 12; i++)
        check("t4_gap", 32'(hs_cycle[base + i] - hs_cycle[base + i - 1]), 32'd3);
    end
    step(3);

    // Reset while an op is in CAPT with two more buffered
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send_op(rand_fs(), $urandom, $urandom, 1'b1, TAG_W'(1 + i));
    wait_valid(n);
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;
    step(1);
    Reset = 1'b0;
    exp_q.delete();
    model_flags = '0;
    #1;
    check("t5_rst_res_valid", 32'(res_valid), 32'd0);
    check("t5_rst_alu_wf", 32'(alu_wf), 32'd0);
    check("t5_rst_res_data", res_data, 32'd0);
    check("t5_rst_res_tag", 32'(res_tag), 32'd0);
    check("t5_rst_in_ready", 32'(in_ready), 32'd1);
    step(2);
    Reset = 1'b1;
    res_before = n_results;
    res_ready = 1'b1;
    step(10);
    check("t5_no_stale_valid", 32'(res_valid), 32'd0);
    check("t5_no_stale_result", 32'(n_results), 32'(res_before));
    res_ready = 1'b0;
    send_op(FS_XOR, 32'hF0F0_1234, 32'h0FF0_4321, 1'b1, 4'h9);
    wait_valid(n);
    check("t5_post_latency", 32'(n), 32'(LAT));
    check("t5_post_tag", 32'(res_tag), 32'h9);
    take_one();
    step(2);

    // Random res_ready toggling: outputs must hold while stalled
    burst(8, 1'b1);
    step(4);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
